// File: rtl/avalon_window_reader.sv
// rtl/avalon_window_reader.sv - Avalon-MM read master fetching a 3x3 pixel window
//
// Purpose: turns a centre coordinate (x,y) into up to nine single-beat Avalon reads
//   and assembles the 3x3 neighbourhood into window_o, tap k at [k*DATA_W +: DATA_W],
//   taps row-major with tap 4 at the centre.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   start_i, x_i, y_i            fetch request for centre (x_i,y_i), sampled in IDLE
//   busy_o, done_o, window_o     status, 1-cycle completion pulse, packed window
//   avm_address_o, avm_read_o    Avalon read request (one outstanding read)
//   avm_waitrequest_i            slave stall
//   avm_readdata_i, avm_readdatavalid_i  read response
// Configuration macro: WINDOW_REPLICATE_EN
//   defined   - out-of-image taps clamp to the nearest edge pixel and are read
//   undefined - out-of-image taps are zero and never read
module avalon_window_reader #(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 32,
  parameter int BASE_ADDR = 0,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [XW-1:0]       x_i,
  input  logic [YW-1:0]       y_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [9*DATA_W-1:0] window_o,
  output logic [ADDR_W-1:0]   avm_address_o,
  output logic                avm_read_o,
  input  logic                avm_waitrequest_i,
  input  logic [31:0]         avm_readdata_i,
  input  logic                avm_readdatavalid_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_SKIP, S_WAIT_DATA, S_DONE
  } state_t;

  // Two guard bits so x-1 and x+1 are representable as signed values.
  localparam logic signed [XW+1:0] XMAX = (XW+2)'(IMG_W - 1);
  localparam logic signed [YW+1:0] YMAX = (YW+2)'(IMG_H - 1);

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [3:0]            k_q, k_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [9*DATA_W-1:0]   win_q, win_d;

  logic signed [XW+1:0]  dx, tx, cx;
  logic signed [YW+1:0]  dy, ty, cy;
  logic                  skip;
  logic [ADDR_W-1:0]     tap_addr;
  logic                  unused_rdata;

  assign unused_rdata = ^avm_readdata_i;

  // Offsets and coordinates of the tap currently indexed by k_q.
  always_comb begin
    dx = '0;
    dy = '0;
    case (k_q)
      4'd0, 4'd3, 4'd6: dx = -(XW+2)'(1);
      4'd1, 4'd4, 4'd7: dx = '0;
      default:          dx = (XW+2)'(1);
    endcase
    if (k_q < 4'd3)      dy = -(YW+2)'(1);
    else if (k_q < 4'd6) dy = '0;
    else                 dy = (YW+2)'(1);
    tx = $signed({2'b00, x_q}) + dx;
    ty = $signed({2'b00, y_q}) + dy;
`ifdef WINDOW_REPLICATE_EN
    cx   = (tx < 0) ? '0 : ((tx > XMAX) ? XMAX : tx);
    cy   = (ty < 0) ? '0 : ((ty > YMAX) ? YMAX : ty);
    skip = 1'b0;
`else
    cx   = tx;
    cy   = ty;
    skip = (tx < 0) || (tx > XMAX) || (ty < 0) || (ty > YMAX);
`endif
    tap_addr = ADDR_W'(BASE_ADDR) + ADDR_W'($unsigned(cy)) * ADDR_W'(IMG_W)
             + ADDR_W'($unsigned(cx));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    k_d        = k_q;
    addr_d     = addr_q;
    win_d      = win_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    avm_read_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_i;
          y_d     = y_i;
          k_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy_o = 1'b1;
        if (skip) begin
          state_d = S_SKIP;
        end else begin
          addr_d  = tap_addr;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy_o     = 1'b1;
        avm_read_o = 1'b1;
        if (!avm_waitrequest_i) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA, S_SKIP: begin
        busy_o = 1'b1;
        // SKIP completes unconditionally with a zero tap; WAIT_DATA waits for data.
        if (state_q == S_SKIP || avm_readdatavalid_i) begin
          win_d[int'(k_q)*DATA_W +: DATA_W] =
            (state_q == S_SKIP) ? '0 : avm_readdata_i[DATA_W-1:0];
          if (k_q == 4'd8) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign avm_address_o = addr_q;
  assign window_o      = win_q;

endmodule

// File: tb/tb_avalon_window_reader.sv
// tb/tb_avalon_window_reader.sv - directed self-checking bench for avalon_window_reader
module tb_avalon_window_reader;

  typedef int taps_t[9];

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  x_i = '0;
  logic [5:0]  y_i = '0;
  logic        busy_o, done_o, avm_read_o, avm_waitrequest_i;
  logic [71:0] window_o;
  logic [31:0] avm_address_o;
  logic [31:0] avm_readdata_i = '0;
  logic        avm_readdatavalid_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  int wait_cnt = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  int stable_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] rd_log[$];

  always #5 clk = ~clk;

  avalon_window_reader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .x_i(x_i), .y_i(y_i),
    .busy_o(busy_o), .done_o(done_o), .window_o(window_o),
    .avm_address_o(avm_address_o), .avm_read_o(avm_read_o),
    .avm_waitrequest_i(avm_waitrequest_i), .avm_readdata_i(avm_readdata_i),
    .avm_readdatavalid_i(avm_readdatavalid_i)
  );

  // Memory: mem[a] = a (low byte is the pixel), read latency 1, wr_cycles stall cycles per read.
  assign avm_waitrequest_i = avm_read_o && (wait_cnt < wr_cycles);

  always @(posedge clk) begin
    avm_readdatavalid_i <= 1'b0;
    if (avm_read_o && !avm_waitrequest_i) begin
      avm_readdatavalid_i <= 1'b1;
      avm_readdata_i      <= avm_address_o;
    end
    if (avm_read_o && avm_waitrequest_i) wait_cnt <= wait_cnt + 1;
    else                                 wait_cnt <= 0;
  end

  always @(negedge clk) begin
    if (done_o) done_cnt <= done_cnt + 1;
    if (avm_read_o && !avm_waitrequest_i) rd_log.push_back(avm_address_o);
    if (avm_read_o && avm_waitrequest_i) stall_cnt <= stall_cnt + 1;
    if (prev_stall && (!avm_read_o || avm_address_o !== prev_addr)) stable_err <= stable_err + 1;
    prev_stall <= avm_read_o && avm_waitrequest_i;
    prev_addr  <= avm_address_o;
  end

  function automatic logic [71:0] win_of(input taps_t t);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) if (t[k] >= 0) w[k*8 +: 8] = t[k][7:0];
    return w;
  endfunction

  function automatic int n_reads(input taps_t t);
    int n;
    n = 0;
    for (int k = 0; k < 9; k++) if (t[k] >= 0) n++;
    return n;
  endfunction

  // 1 when the reads logged from index base onward are exactly the non-padded taps, in order.
  function automatic bit reads_match(input taps_t t, input int base);
    int j;
    bit ok;
    j  = base;
    ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (t[k] >= 0) begin
        if (j >= rd_log.size() || rd_log[j] !== t[k]) ok = 1'b0;
        j++;
      end
    end
    if (j != rd_log.size()) ok = 1'b0;
    return ok;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_fetch(input int x, input int y, output bit timed_out);
    start_i = 1'b1;
    x_i = 6'(x);
    y_i = 6'(y);
    tick();
    start_i = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (done_o) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy_o, done_o, avm_read_o} !== 3'b000 || avm_address_o !== 32'd0 || window_o !== 72'd0)
      begin errors++; $display("FAIL reset_state: busy=%b done=%b read=%b addr=%h win=%h, required all 0",
                               busy_o, done_o, avm_read_o, avm_address_o, window_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_interior();
    taps_t t = '{585, 586, 587, 649, 650, 651, 713, 714, 715};
    int base = rd_log.size();
    int d0 = done_cnt;
    bit to;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy_o); end
    do_fetch(10, 10, to);
    checks++;
    if (to) begin errors++; $display("FAIL interior_timeout: done_o not seen"); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL interior_done_count: got %0d required 1", done_cnt - d0); end
    checks++;
    if (!reads_match(t, base)) begin errors++; $display("FAIL interior_reads: got %0d reads required %0d at 585..715", rd_log.size() - base, n_reads(t)); end
    checks++;
    if (window_o !== win_of(t)) begin errors++; $display("FAIL interior_window: got %h required %h", window_o, win_of(t)); end
  endtask

  task automatic test_corner_origin();
`ifdef WINDOW_REPLICATE_EN
    taps_t t = '{0, 0, 1, 0, 0, 1, 64, 64, 65};
`else
    taps_t t = '{-1, -1, -1, -1, 0, 1, -1, 64, 65};
`endif
    int base = rd_log.size();
    bit to;
    do_fetch(0, 0, to);
    checks++;
    if (to) begin errors++; $display("FAIL origin_timeout: done_o not seen"); end
    checks++;
    if (!reads_match(t, base)) begin errors++; $display("FAIL origin_reads: got %0d reads required %0d", rd_log.size() - base, n_reads(t)); end
    checks++;
    if (window_o !== win_of(t)) begin errors++; $display("FAIL origin_window: got %h required %h", window_o, win_of(t)); end
  endtask

  task automatic test_corner_waitrequest();
`ifdef WINDOW_REPLICATE_EN
    taps_t t = '{4030, 4031, 4031, 4094, 4095, 4095, 4094, 4095, 4095};
`else
    taps_t t = '{4030, 4031, -1, 4094, 4095, -1, -1, -1, -1};
`endif
    int base = rd_log.size();
    int s0 = stall_cnt;
    int e0 = stable_err;
    bit to;
    wr_cycles = 3;
    do_fetch(63, 63, to);
    wr_cycles = 0;
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: done_o not seen"); end
    checks++;
    if (!reads_match(t, base)) begin errors++; $display("FAIL stall_reads: got %0d reads required %0d", rd_log.size() - base, n_reads(t)); end
    checks++;
    if (stall_cnt - s0 !== 3 * n_reads(t)) begin errors++; $display("FAIL stall_cycles: got %0d required %0d", stall_cnt - s0, 3 * n_reads(t)); end
    checks++;
    if (stable_err - e0 !== 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles required 0", stable_err - e0); end
    checks++;
    if (window_o !== win_of(t)) begin errors++; $display("FAIL stall_window: got %h required %h", window_o, win_of(t)); end
  endtask

  task automatic test_start_ignored();
    taps_t t1 = '{260, 261, 262, 324, 325, 326, 388, 389, 390};
    taps_t t2 = '{1235, 1236, 1237, 1299, 1300, 1301, 1363, 1364, 1365};
    int base = rd_log.size();
    int d0 = done_cnt;
    bit seen = 1'b0;
    bit to;
    start_i = 1'b1; x_i = 6'd5; y_i = 6'd5;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    start_i = 1'b1; x_i = 6'd20; y_i = 6'd20;
    tick();
    start_i = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (done_o) begin seen = 1'b1; break; end
      tick();
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (!seen) begin errors++; $display("FAIL ignore_timeout: done_o not seen"); end
    checks++;
    if (busy_o !== 1'b0 || done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore_restart: busy=%b dones=%0d required busy 0, 1 done", busy_o, done_cnt - d0); end
    checks++;
    if (!reads_match(t1, base)) begin errors++; $display("FAIL ignore_reads: got %0d reads required 9 for (5,5)", rd_log.size() - base); end
    checks++;
    if (window_o !== win_of(t1)) begin errors++; $display("FAIL ignore_window: got %h required %h", window_o, win_of(t1)); end
    base = rd_log.size();
    do_fetch(20, 20, to);
    checks++;
    if (to || !reads_match(t2, base) || window_o !== win_of(t2)) begin errors++; $display("FAIL later_start: timeout=%b reads=%0d win=%h required 9 reads win %h", to, rd_log.size() - base, window_o, win_of(t2)); end
  endtask

  task automatic test_reset_midfetch();
    taps_t t = '{585, 586, 587, 649, 650, 651, 713, 714, 715};
    int base;
    bit hit = 1'b0;
    bit to;
    start_i = 1'b1; x_i = 6'd10; y_i = 6'd10;
    tick();
    start_i = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (avm_read_o && !avm_waitrequest_i) begin hit = 1'b1; break; end
      tick();
    end
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (!hit || {busy_o, done_o, avm_read_o} !== 3'b000 || avm_address_o !== 32'd0 || window_o !== 72'd0)
      begin errors++; $display("FAIL midfetch_reset: hit=%b busy=%b done=%b read=%b addr=%h win=%h required all 0",
                               hit, busy_o, done_o, avm_read_o, avm_address_o, window_o); end
    tick();
    rst_i = 1'b0;
    tick();
    base = rd_log.size();
    do_fetch(10, 10, to);
    checks++;
    if (to || !reads_match(t, base) || window_o !== win_of(t)) begin errors++; $display("FAIL after_reset_fetch: timeout=%b reads=%0d win=%h required %h", to, rd_log.size() - base, window_o, win_of(t)); end
  endtask

  initial begin
    test_reset();
    test_interior();
    test_corner_origin();
    test_corner_waitrequest();
    test_start_ignored();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
